// File: rtl/booth_mul_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
//   - state_t       : controller states (IDLE, RUN)
//   - PAIR_ADD/SUB  : encodings of the {Q[0],Q_1} Booth pair
//   - booth_addsub  : add/subtract step on a wide, already sign-extended word.
//                     Callers sign-extend into STEP_MAX_W+1 bits and keep the
//                     low bits they need, so one function serves every WIDTH.
package booth_mul_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] PAIR_ADD = 2'b01;
  localparam logic [1:0] PAIR_SUB = 2'b10;

  // Widest accumulator the helper supports (WIDTH must stay below this).
  localparam int STEP_MAX_W = 64;

  function automatic logic [STEP_MAX_W:0] booth_addsub(
    input logic [1:0]          pair,
    input logic [STEP_MAX_W:0] acc,
    input logic [STEP_MAX_W:0] m
  );
    case (pair)
      PAIR_ADD: return acc + m;
      PAIR_SUB: return acc - m;
      default:  return acc;
    endcase
  endfunction

endpackage

// File: rtl/booth_mul_step.sv
// One combinational Booth iteration: add/sub of the multiplicand selected by
// {q[0],q_1}, followed by an arithmetic right shift of {acc,q,q_1}.
// Ports:
//   acc   [WIDTH:0]   partial accumulator (one guard bit so -M cannot overflow)
//   q     [WIDTH-1:0] multiplier / low product bits
//   q_1               previously shifted-out multiplier bit
//   m     [WIDTH-1:0] signed multiplicand
//   acc_nx, q_nx, q_1_nx : values after this iteration
module booth_mul_step
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   acc_nx,
  output logic [WIDTH-1:0] q_nx,
  output logic             q_1_nx
);

  logic [STEP_MAX_W:0] acc_w;
  logic [STEP_MAX_W:0] m_w;
  logic [STEP_MAX_W:0] sum_w;
  logic [WIDTH:0]      sum;
  logic                unused_sum_hi;

  assign acc_w = {{(STEP_MAX_W - WIDTH){acc[WIDTH]}}, acc};
  assign m_w   = {{(STEP_MAX_W + 1 - WIDTH){m[WIDTH-1]}}, m};
  assign sum_w = booth_addsub({q[0], q_1}, acc_w, m_w);
  assign sum   = sum_w[WIDTH:0];
  // Bits above the guard bit are pure sign extension; nothing needs them.
  assign unused_sum_hi = ^sum_w[STEP_MAX_W:WIDTH+1];

  // Arithmetic shift right of {sum, q, q_1}: sign bit replicated.
  assign acc_nx = {sum[WIDTH], sum[WIDTH:1]};
  assign q_nx   = {sum[0], q[WIDTH-1:1]};
  assign q_1_nx = q[0];

endmodule

// File: rtl/booth_mul.sv
// Sequential radix-2 Booth multiplier: signed a * signed b -> signed c (2*WIDTH).
// One iteration per clock; done pulses WIDTH edges after the accepting edge and
// c holds its value until the next completion.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request, sampled only while busy=0
//   a, b         signed operands, captured on the accepting edge
//   busy         high from the accepting edge until the completion edge
//   done         one-cycle completion pulse
//   c            registered signed product
// Configuration macro: BOOTH_MUL_ZERO_BYPASS_EN -- when defined, a zero operand
// completes on the accepting edge itself (c=0, done pulse, busy stays low).
module booth_mul
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] c
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state, state_nx;
  logic [WIDTH-1:0]   m, m_nx;
  logic [WIDTH:0]     acc, acc_nx;
  logic [WIDTH-1:0]   q, q_nx;
  logic               q_1, q_1_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [2*WIDTH-1:0] c_nx;
  logic               done_nx;

  logic [WIDTH:0]     step_acc;
  logic [WIDTH-1:0]   step_q;
  logic               step_q_1;
  logic               bypass;

  booth_mul_step #(.WIDTH(WIDTH)) u_step (
    .acc    (acc),
    .q      (q),
    .q_1    (q_1),
    .m      (m),
    .acc_nx (step_acc),
    .q_nx   (step_q),
    .q_1_nx (step_q_1)
  );

`ifdef BOOTH_MUL_ZERO_BYPASS_EN
  assign bypass = (a == '0) || (b == '0);
`else
  assign bypass = 1'b0;
`endif

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      cnt   <= '0;
      c     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      m     <= m_nx;
      acc   <= acc_nx;
      q     <= q_nx;
      q_1   <= q_1_nx;
      cnt   <= cnt_nx;
      c     <= c_nx;
      done  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    m_nx     = m;
    acc_nx   = acc;
    q_nx     = q;
    q_1_nx   = q_1;
    cnt_nx   = cnt;
    c_nx     = c;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (bypass) begin
            c_nx    = '0;
            done_nx = 1'b1;
          end else begin
            m_nx     = a;
            acc_nx   = '0;
            q_nx     = b;
            q_1_nx   = 1'b0;
            cnt_nx   = CW'(WIDTH);
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        acc_nx = step_acc;
        q_nx   = step_q;
        q_1_nx = step_q_1;
        cnt_nx = cnt - 1'b1;
        // Last iteration: the product is the post-shift {A,Q} low 2*WIDTH bits.
        if (cnt == CW'(1)) begin
          c_nx     = {step_acc[WIDTH-1:0], step_q};
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_booth_mul.sv
// Self-checking bench for booth_mul (WIDTH=4): a cycle-level behavioural model
// (plain signed multiply + remaining-edge counter) is compared with the DUT on
// every falling edge, alongside literal directed cases and an exhaustive sweep.
module tb_booth_mul;

  localparam int W = 4;
`ifdef BOOTH_MUL_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] c;

  booth_mul #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .c     (c)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] sprod(input logic [W-1:0] x, input logic [W-1:0] y);
    int p;
    logic [31:0] pv;
    p  = int'($signed(x)) * int'($signed(y));
    pv = p;
    return pv[2*W-1:0];
  endfunction

  // Behavioural model: an accepted op completes WIDTH edges later.
  logic           m_busy, m_done;
  logic [2*W-1:0] m_c, m_pend;
  int             m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_c <= '0; m_pend <= '0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0; m_c <= m_pend; m_done <= 1'b1;
        end
        m_left <= m_left - 1;
      end else if (start) begin
        if (BYP && (a == '0 || b == '0)) begin
          m_c <= '0; m_done <= 1'b1;
        end else begin
          m_pend <= sprod(a, b); m_busy <= 1'b1; m_left <= W;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_c", 32'(c), 32'(m_c));
      chk("model_busy", 32'(busy), 32'(m_busy));
      chk("model_done", 32'(done), 32'(m_done));
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issue one op at a falling edge and check result and edge latency.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2*W-1:0] exp, input string name);
    int n = 0;
    wait_idle();
    start = 1'b1; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    while (!done && n < 20) begin @(negedge clk); n++; end
    chk({name, "_c"}, 32'(c), 32'(exp));
    chk({name, "_lat"}, 32'(n), (BYP && (x == '0 || y == '0)) ? 32'd0 : 32'(W));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_c", 32'(c), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Literal expectations (also pin the model).
    run_op(4'hC, 4'hC, 8'h10, "m4xm4");
    run_op(4'hF, 4'hF, 8'h01, "m1xm1");
    run_op(4'h1, 4'h1, 8'h01, "1x1");
    run_op(4'h3, 4'h0, 8'h00, "3x0");
    run_op(4'h3, 4'h5, 8'h0F, "3x5");
    run_op(4'hB, 4'h9, 8'h23, "m5xm7");
    run_op(4'h4, 4'hE, 8'hF8, "4xm2");
    run_op(4'h8, 4'hB, 8'h28, "m8xm5");
    run_op(4'h8, 4'h8, 8'h40, "m8xm8");
    run_op(4'h8, 4'h7, 8'hC8, "m8x7");

    // Re-pulse start while busy: ignored, single done with first result.
    begin
      int nd = 0;
      wait_idle();
      start = 1'b1; a = 4'h3; b = 4'h5;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; a = 4'h7; b = 4'h7;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (done) nd++;
        @(negedge clk);
      end
      chk("busy_ignore_c", 32'(c), 32'h0F);
      chk("busy_ignore_ndone", 32'(nd), 32'd1);
    end

    // Reset during RUN aborts immediately.
    wait_idle();
    start = 1'b1; a = 4'h5; b = 4'h3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_c", 32'(c), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'h6, 4'hD, 8'hEE, "after_rst");

    // Exhaustive sweep against plain signed arithmetic.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run_op(W'(i), W'(j), sprod(W'(i), W'(j)), "exh");

    // Random traffic, including start held high and starts while busy.
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      start = (k % 100 < 30) ? 1'b1 : ($urandom_range(0, 2) == 0);
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 7) == 0) a = '0;
    end
    start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
